nrs_ls_chest: RTL and testbench
===============================

Name: nrs_ls_chest

Overview:
Least-squares channel estimator at NB-IoT NRS resource elements; sits directly downstream of NRS_top and consumes its nrs_est read port.
For each received NRS RE y(k), k=0..7 per subframe, it fetches x(k) from NRS_top at addresses 2k (real) and 2k+1 (imag).
It outputs h(k) = y(k)·conj(x(k)) in Q5.11; |x|²=1, so no division is needed.
Results feed the downstream channel interpolation/equalizer.

Parameters:
WIDTH_IQ, 16, width of y, x and h components; signed Q5.11
FRAC, 11, fractional bits of all operands and results
NRS_PER_SF, 8, complex NRS REs per subframe
ADDR_W, 4, NRS_top read-address width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
new_frame  in  1  one-cycle pulse; same pulse that drives NRS_top
nrs_rdy  in  1  level; NRS_top memory holds the current subframe's values
re_valid  in  1  received-RE strobe
re_ready  out  1  block can accept an RE this cycle
re_idx  in  3  RE index within the subframe, expected 0..7 in order
re_r, re_i  in  16 each  received RE, Q5.11
rd_addr_est  out  4  registered read address to NRS_top
nrs_est  in  16  NRS_top data, valid one clock after the address is sampled
h_valid  out  1  one-cycle result strobe
h_idx  out  3  index of the result
h_r, h_i  out  16 each  LS estimate, Q5.11, saturated
sf_done  out  1  one-cycle pulse after h_idx=7 is emitted
idx_err  out  1  one-cycle pulse when re_idx ≠ expected index; that RE is dropped

Behaviour:
- Reset: all outputs 0, FSM=IDLE, expected-index counter cnt=0.
- States:
  - IDLE: re_ready=0. Goes to ARMED when nrs_rdy=1.
  - ARMED: re_ready=1. On re_valid with re_idx==cnt: latch y, rd_addr_est<=2·cnt, go FETCH_I.
    - On re_valid with re_idx≠cnt: idx_err pulse, stay ARMED, cnt unchanged.
  - FETCH_I: rd_addr_est<=2·cnt+1, go CAP_R.
  - CAP_R: latch xr from nrs_est, go CAP_I.
  - CAP_I: latch xi, go MUL.
  - MUL: register the four 32-bit signed products, go OUT.
  - OUT: h_valid=1 with h_idx=cnt.
    - If cnt=7: sf_done=1 in the same cycle, cnt<=0, go IDLE.
    - Else: cnt<=cnt+1, go ARMED.
- Latency: h_valid is asserted 5 clocks after the accepting edge. Throughput is one RE per 6 clocks; re_ready is high only in ARMED.
- Arithmetic:
  - sr = yr·xr + yi·xi; si = yi·xr − yr·xi, both 33-bit signed.
  - Round half-up: add 2^(FRAC−1), then arithmetic shift right by FRAC.
  - Saturate to [−32768, 32767].
- h_r/h_i/h_idx hold their last values outside h_valid.
- new_frame has priority over everything in every state: go IDLE, cnt<=0, drop any in-flight RE, no h_valid, no sf_done in that or the next cycle.
- nrs_rdy deasserted mid-subframe: the current RE completes normally; the FSM then waits in IDLE, keeping cnt, and resumes when nrs_rdy returns.
- re_valid in any non-ARMED state is ignored (re_ready=0); no error is flagged.
- Asynchronous reset mid-operation: immediate return to the reset state.

Decomposition:
- Shared package: WIDTH_IQ, FRAC, NRS_PER_SF, ADDR_W; the constant NRS_POS = 16'h05A8 and NRS_NEG = 16'hFA58; the state enum {IDLE, ARMED, FETCH_I, CAP_R, CAP_I, MUL, OUT}.
- Sub-module nrs_cmul_rnd: conj complex multiply, round and saturate, with its product register (MUL stage).
- FSM, counter and address generation stay in the top.

Test Plan:
- T1: y=(0x0800,0x0000), x=(0x05A8,0x05A8) → h_r=0x05A8, h_i=0xFA58; h_valid 5 clocks after accept; rd_addr_est sequence 0,1.
- T2: y=(0x7FFF,0x7FFF), x=(0x05A8,0x05A8) → h_r saturates to 0x7FFF, h_i=0x0000.
- T3: y=(0x0800,0x0800), x=(0xFA58,0xFA58) → h_r=0xF4B0 (−2896), h_i=0x0000.
- T4: full subframe, idx 0..7 with random y and values driven by an NRS_top model.
  - h matches a reference model bit-exactly.
  - rd_addr_est walks 0..15.
  - sf_done pulses with h_idx=7; FSM returns to IDLE.
- T5: send re_idx=3 when 2 is expected → idx_err pulse, no h_valid, next RE with idx 2 accepted.
- T6: new_frame while in CAP_R for idx 4 → no h_valid for idx 4, cnt=0, re_ready=0 until nrs_rdy; after nrs_rdy, idx 0 is accepted.

Source files
------------

// File: rtl/nrs_ls_chest_pkg.sv
// Shared constants, state encoding and arithmetic helper for the NRS
// least-squares channel estimator.
package nrs_ls_chest_pkg;

   localparam int WIDTH_IQ   = 16;
   localparam int FRAC       = 11;
   localparam int NRS_PER_SF = 8;
   localparam int ADDR_W     = 4;
   localparam int IDX_W      = 3;
   localparam int PROD_W     = 2 * WIDTH_IQ;
   localparam int SUM_W      = PROD_W + 2;

   // NRS symbol components are +/- 1/sqrt(2) in Q5.11
   localparam logic [WIDTH_IQ-1:0] NRS_POS = 16'h05A8;
   localparam logic [WIDTH_IQ-1:0] NRS_NEG = 16'hFA58;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      FETCH_I = 3'd2,
      CAP_R   = 3'd3,
      CAP_I   = 3'd4,
      MUL     = 3'd5,
      OUT     = 3'd6
   } nrs_state_e;

   // Round half-up at the FRAC boundary, then clamp into the Q5.11 range.
   function automatic logic [WIDTH_IQ-1:0] round_sat(input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W-1:0] r;
      r = (s + (SUM_W'(1) <<< (FRAC - 1))) >>> FRAC;
      if (r > SUM_W'(32767)) begin
         round_sat = 16'h7FFF;
      end else if (r < -SUM_W'(32768)) begin
         round_sat = 16'h8000;
      end else begin
         round_sat = r[WIDTH_IQ-1:0];
      end
   endfunction

endpackage

// File: rtl/nrs_ls_chest_cmul_rnd.sv
// Conjugate complex multiply y*conj(x): product register loaded in the MUL
// stage, followed by combinational sum, rounding and saturation.
module nrs_cmul_rnd
   import nrs_ls_chest_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mul_en,
   input  logic signed [WIDTH_IQ-1:0] y_r,
   input  logic signed [WIDTH_IQ-1:0] y_i,
   input  logic signed [WIDTH_IQ-1:0] x_r,
   input  logic signed [WIDTH_IQ-1:0] x_i,
   output logic        [WIDTH_IQ-1:0] h_r,
   output logic        [WIDTH_IQ-1:0] h_i
);

   logic signed [PROD_W-1:0] p_rr_q, p_rr_d;   // yr*xr
   logic signed [PROD_W-1:0] p_ii_q, p_ii_d;   // yi*xi
   logic signed [PROD_W-1:0] p_ir_q, p_ir_d;   // yi*xr
   logic signed [PROD_W-1:0] p_ri_q, p_ri_d;   // yr*xi
   logic signed [SUM_W-1:0]  s_r, s_i;

   // Load the four partial products only when the FSM is in MUL
   always_comb begin
      p_rr_d = p_rr_q;
      p_ii_d = p_ii_q;
      p_ir_d = p_ir_q;
      p_ri_d = p_ri_q;
      if (mul_en) begin
         p_rr_d = y_r * x_r;
         p_ii_d = y_i * x_i;
         p_ir_d = y_i * x_r;
         p_ri_d = y_r * x_i;
      end
   end

   // Product register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_rr_q <= '0;
         p_ii_q <= '0;
         p_ir_q <= '0;
         p_ri_q <= '0;
      end else begin
         p_rr_q <= p_rr_d;
         p_ii_q <= p_ii_d;
         p_ir_q <= p_ir_d;
         p_ri_q <= p_ri_d;
      end
   end

   // Sign-extended sums for the conjugate product, then round and clamp
   always_comb begin
      s_r = {{2{p_rr_q[PROD_W-1]}}, p_rr_q} + {{2{p_ii_q[PROD_W-1]}}, p_ii_q};
      s_i = {{2{p_ir_q[PROD_W-1]}}, p_ir_q} - {{2{p_ri_q[PROD_W-1]}}, p_ri_q};
      h_r = round_sat(s_r);
      h_i = round_sat(s_i);
   end

endmodule

// File: rtl/nrs_ls_chest.sv
// LS channel estimator at NRS resource elements. Each accepted RE fetches
// its reference symbol from NRS_top (addresses 2k, 2k+1) and emits
// h(k) = y(k)*conj(x(k)) five clocks after acceptance.
//
// Handshake: an RE transfers on a rising edge where re_valid and re_ready
// are both high; re_ready is high only in ARMED and never depends on
// re_valid. Results are one-cycle h_valid strobes with no back-pressure.
module nrs_ls_chest
   import nrs_ls_chest_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                new_frame,
   input  logic                nrs_rdy,
   input  logic                re_valid,
   output logic                re_ready,
   input  logic [IDX_W-1:0]    re_idx,
   input  logic [WIDTH_IQ-1:0] re_r,
   input  logic [WIDTH_IQ-1:0] re_i,
   output logic [ADDR_W-1:0]   rd_addr_est,
   input  logic [WIDTH_IQ-1:0] nrs_est,
   output logic                h_valid,
   output logic [IDX_W-1:0]    h_idx,
   output logic [WIDTH_IQ-1:0] h_r,
   output logic [WIDTH_IQ-1:0] h_i,
   output logic                sf_done,
   output logic                idx_err,
   output logic [2:0]          state_dbg
);

   nrs_state_e          state_q, state_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic [WIDTH_IQ-1:0] yr_q, yr_d, yi_q, yi_d;
   logic [WIDTH_IQ-1:0] xr_q, xr_d, xi_q, xi_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                h_valid_q, h_valid_d;
   logic [IDX_W-1:0]    h_idx_q, h_idx_d;
   logic [WIDTH_IQ-1:0] h_r_q, h_r_d, h_i_q, h_i_d;
   logic                sf_done_q, sf_done_d;
   logic                idx_err_q, idx_err_d;
   logic                mul_en;
   logic [WIDTH_IQ-1:0] hr_c, hi_c;

   nrs_cmul_rnd u_cmul (
      .clk    (clk),
      .rst    (rst),
      .mul_en (mul_en),
      .y_r    (yr_q),
      .y_i    (yi_q),
      .x_r    (xr_q),
      .x_i    (xi_q),
      .h_r    (hr_c),
      .h_i    (hi_c)
   );

   // Next-state, counter, address and output-register logic; new_frame wins
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      yr_d      = yr_q;
      yi_d      = yi_q;
      xr_d      = xr_q;
      xi_d      = xi_q;
      rd_addr_d = rd_addr_q;
      h_idx_d   = h_idx_q;
      h_r_d     = h_r_q;
      h_i_d     = h_i_q;
      h_valid_d = 1'b0;
      sf_done_d = 1'b0;
      idx_err_d = 1'b0;
      mul_en    = 1'b0;
      if (new_frame) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (nrs_rdy) state_d = ARMED;
            end
            ARMED: begin
               if (re_valid) begin
                  if (re_idx == cnt_q) begin
                     yr_d      = re_r;
                     yi_d      = re_i;
                     rd_addr_d = {cnt_q, 1'b0};
                     state_d   = FETCH_I;
                  end else begin
                     idx_err_d = 1'b1;
                  end
               end else if (!nrs_rdy) begin
                  state_d = IDLE;
               end
            end
            FETCH_I: begin
               rd_addr_d = {cnt_q, 1'b1};
               state_d   = CAP_R;
            end
            CAP_R: begin
               xr_d    = nrs_est;
               state_d = CAP_I;
            end
            CAP_I: begin
               xi_d    = nrs_est;
               state_d = MUL;
            end
            MUL: begin
               mul_en  = 1'b1;
               state_d = OUT;
            end
            OUT: begin
               h_valid_d = 1'b1;
               h_idx_d   = cnt_q;
               h_r_d     = hr_c;
               h_i_d     = hi_c;
               if (cnt_q == IDX_W'(NRS_PER_SF - 1)) begin
                  sf_done_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = nrs_rdy ? ARMED : IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         yr_q      <= '0;
         yi_q      <= '0;
         xr_q      <= '0;
         xi_q      <= '0;
         rd_addr_q <= '0;
         h_valid_q <= 1'b0;
         h_idx_q   <= '0;
         h_r_q     <= '0;
         h_i_q     <= '0;
         sf_done_q <= 1'b0;
         idx_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         yr_q      <= yr_d;
         yi_q      <= yi_d;
         xr_q      <= xr_d;
         xi_q      <= xi_d;
         rd_addr_q <= rd_addr_d;
         h_valid_q <= h_valid_d;
         h_idx_q   <= h_idx_d;
         h_r_q     <= h_r_d;
         h_i_q     <= h_i_d;
         sf_done_q <= sf_done_d;
         idx_err_q <= idx_err_d;
      end
   end

   assign re_ready    = (state_q == ARMED);
   assign rd_addr_est = rd_addr_q;
   assign h_valid     = h_valid_q;
   assign h_idx       = h_idx_q;
   assign h_r         = h_r_q;
   assign h_i         = h_i_q;
   assign sf_done     = sf_done_q;
   assign idx_err     = idx_err_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_nrs_ls_chest.sv
// Directed bench for nrs_ls_chest with a registered NRS_top memory model.
module tb_nrs_ls_chest;
   import nrs_ls_chest_pkg::*;

   logic        clk;
   logic        rst;
   logic        new_frame;
   logic        nrs_rdy;
   logic        re_valid;
   logic        re_ready;
   logic [2:0]  re_idx;
   logic [15:0] re_r, re_i;
   logic [3:0]  rd_addr_est;
   logic [15:0] nrs_est;
   logic        h_valid;
   logic [2:0]  h_idx;
   logic [15:0] h_r, h_i;
   logic        sf_done;
   logic        idx_err;
   logic [2:0]  state_dbg;

   logic [15:0] nrs_mem [16];
   int          n_chk;
   int          n_fail;

   nrs_ls_chest dut (
      .clk         (clk),
      .rst         (rst),
      .new_frame   (new_frame),
      .nrs_rdy     (nrs_rdy),
      .re_valid    (re_valid),
      .re_ready    (re_ready),
      .re_idx      (re_idx),
      .re_r        (re_r),
      .re_i        (re_i),
      .rd_addr_est (rd_addr_est),
      .nrs_est     (nrs_est),
      .h_valid     (h_valid),
      .h_idx       (h_idx),
      .h_r         (h_r),
      .h_i         (h_i),
      .sf_done     (sf_done),
      .idx_err     (idx_err),
      .state_dbg   (state_dbg)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // NRS_top model: data valid one clock after the address is sampled
   always @(posedge clk) nrs_est <= nrs_mem[rd_addr_est];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: round half-up at bit 11, saturate to 16-bit signed
   function automatic logic [15:0] ref_sat(input longint s);
      longint r;
      r = (s + 1024) >>> 11;
      if (r > 32767) return 16'h7FFF;
      if (r < -32768) return 16'h8000;
      return 16'(r);
   endfunction

   function automatic logic [15:0] ref_hr(input logic [15:0] yr, yi, xr, xi);
      longint a, b, c, d;
      a = longint'($signed(yr)); b = longint'($signed(yi));
      c = longint'($signed(xr)); d = longint'($signed(xi));
      return ref_sat(a * c + b * d);
   endfunction

   function automatic logic [15:0] ref_hi(input logic [15:0] yr, yi, xr, xi);
      longint a, b, c, d;
      a = longint'($signed(yr)); b = longint'($signed(yi));
      c = longint'($signed(xr)); d = longint'($signed(xi));
      return ref_sat(b * c - a * d);
   endfunction

   task automatic wait_armed(input string tag);
      int n;
      n = 0;
      while (state_dbg !== 3'(ARMED) && n < 10) begin
         tick();
         n++;
      end
      check({tag, "_armed"}, 32'(state_dbg), 32'(ARMED));
   endtask

   // driver: one RE through the pipeline, checking addresses, latency and result
   task automatic run_re(input int idx, input logic [15:0] yr, yi, exp_hr, exp_hi, input string tag);
      int  lat;
      wait_armed(tag);
      re_valid = 1'b1; re_idx = 3'(idx); re_r = yr; re_i = yi;
      tick();
      re_valid = 1'b0;
      check({tag, "_addr_r"}, 32'(rd_addr_est), 32'(2 * idx));
      lat = 0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         tick();
         if (c == 1) check({tag, "_addr_i"}, 32'(rd_addr_est), 32'(2 * idx + 1));
         if (h_valid) lat = c;
      end
      check({tag, "_latency"}, 32'(lat), 32'd5);
      check({tag, "_h_r"}, 32'(h_r), 32'(exp_hr));
      check({tag, "_h_i"}, 32'(h_i), 32'(exp_hi));
      check({tag, "_h_idx"}, 32'(h_idx), 32'(idx));
      check({tag, "_sf_done"}, 32'(sf_done), 32'(idx == 7));
      if (idx == 7) check({tag, "_state_idle"}, 32'(state_dbg), 32'(IDLE));
      tick();
      check({tag, "_h_valid_pulse"}, 32'(h_valid), 32'd0);
      check({tag, "_h_r_hold"}, 32'(h_r), 32'(exp_hr));
   endtask

   initial begin
      logic [15:0] pat [16];
      logic [15:0] ytab_r [8];
      logic [15:0] ytab_i [8];
      int          hv_seen;
      n_chk = 0; n_fail = 0;
      rst = 1'b0; new_frame = 1'b0; nrs_rdy = 1'b0; re_valid = 1'b0;
      re_idx = '0; re_r = '0; re_i = '0;
      for (int k = 0; k < 16; k++) nrs_mem[k] = '0;
      repeat (3) tick();

      // reset state
      check("rst_h_valid", 32'(h_valid), 32'd0);
      check("rst_re_ready", 32'(re_ready), 32'd0);
      check("rst_addr", 32'(rd_addr_est), 32'd0);
      check("rst_h_r", 32'(h_r), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      rst = 1'b1;
      tick();
      check("idle_no_rdy", 32'(re_ready), 32'd0);
      nrs_rdy = 1'b1;

      // T1 / T2: unit-magnitude NRS, saturation
      nrs_mem[0] = NRS_POS; nrs_mem[1] = NRS_POS;
      nrs_mem[2] = NRS_POS; nrs_mem[3] = NRS_POS;
      nrs_mem[4] = NRS_NEG; nrs_mem[5] = NRS_NEG;
      run_re(0, 16'h0800, 16'h0000, 16'h05A8, 16'hFA58, "t1");
      run_re(1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, "t2");

      // T5: out-of-order index is dropped with an error pulse
      wait_armed("t5");
      re_valid = 1'b1; re_idx = 3'd3; re_r = 16'h1111; re_i = 16'h2222;
      tick();
      re_valid = 1'b0;
      check("t5_idx_err", 32'(idx_err), 32'd1);
      check("t5_state", 32'(state_dbg), 32'(ARMED));
      tick();
      check("t5_err_pulse", 32'(idx_err), 32'd0);
      check("t5_no_h", 32'(h_valid), 32'd0);

      // T3: negative NRS, accepted at the expected index 2
      run_re(2, 16'h0800, 16'h0800, 16'hF4B0, 16'h0000, "t3");

      // new_frame restarts the subframe count
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      check("nf_state", 32'(state_dbg), 32'(IDLE));

      // T4: full subframe against the reference model
      pat = '{NRS_POS, NRS_NEG, NRS_NEG, NRS_POS, NRS_POS, NRS_POS, NRS_NEG, NRS_NEG,
              NRS_POS, NRS_NEG, NRS_NEG, NRS_NEG, NRS_POS, NRS_POS, NRS_NEG, NRS_POS};
      ytab_r = '{16'h0800, 16'h1234, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h0400, 16'h3C00};
      ytab_i = '{16'h0000, 16'hF00F, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'hFC00, 16'h4400};
      for (int k = 0; k < 16; k++) nrs_mem[k] = pat[k];
      for (int k = 0; k < 8; k++) begin
         run_re(k, ytab_r[k], ytab_i[k],
                ref_hr(ytab_r[k], ytab_i[k], pat[2*k], pat[2*k+1]),
                ref_hi(ytab_r[k], ytab_i[k], pat[2*k], pat[2*k+1]),
                $sformatf("t4_%0d", k));
      end

      // T6: new_frame while idx 4 is in CAP_R
      for (int k = 0; k < 4; k++) begin
         run_re(k, ytab_r[k], ytab_i[k],
                ref_hr(ytab_r[k], ytab_i[k], pat[2*k], pat[2*k+1]),
                ref_hi(ytab_r[k], ytab_i[k], pat[2*k], pat[2*k+1]),
                $sformatf("t6_pre_%0d", k));
      end
      wait_armed("t6");
      re_valid = 1'b1; re_idx = 3'd4; re_r = ytab_r[4]; re_i = ytab_i[4];
      tick();
      re_valid = 1'b0;
      tick();
      check("t6_in_cap_r", 32'(state_dbg), 32'(CAP_R));
      new_frame = 1'b1; nrs_rdy = 1'b0;
      tick();
      new_frame = 1'b0;
      check("t6_state_idle", 32'(state_dbg), 32'(IDLE));
      hv_seen = 0;
      re_valid = 1'b1; re_idx = 3'd0;
      for (int c = 0; c < 8; c++) begin
         if (h_valid || sf_done || re_ready || idx_err) hv_seen++;
         tick();
      end
      re_valid = 1'b0;
      check("t6_quiet", 32'(hv_seen), 32'd0);
      nrs_rdy = 1'b1;
      run_re(0, ytab_r[5], ytab_i[5],
             ref_hr(ytab_r[5], ytab_i[5], pat[0], pat[1]),
             ref_hi(ytab_r[5], ytab_i[5], pat[0], pat[1]), "t6_post");

      // asynchronous reset mid-operation
      re_valid = 1'b1; re_idx = 3'd1; re_r = 16'h0800; re_i = 16'h0000;
      tick();
      re_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst_state", 32'(state_dbg), 32'(IDLE));
      check("arst_addr", 32'(rd_addr_est), 32'd0);
      check("arst_h_r", 32'(h_r), 32'd0);
      tick();
      rst = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
